// File: rtl/asm_seq_ctrl.sv
// Sequencer for one ASM binarized-neuron datapath: walks every neuron of a layer and drives ASM strobes
// and the pixel/weight/BN memory read addresses. Define ASM_SEQ_PERF_EN to add the busy_cycles counter.
module asm_seq_ctrl #(
  parameter  int N_INPUTS  = 784,
  parameter  int N_NEURONS = 128,
  localparam int PIX_AW    = $clog2(N_INPUTS),
  localparam int W_AW      = $clog2(N_INPUTS * N_NEURONS),
  localparam int NEU_AW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [W_AW-1:0]   w_addr,
  output logic [NEU_AW-1:0] bn_addr,
  output logic              asm_reception,
  output logic              calculate_en,
  output logic              asm_send,
  output logic              out_we,
`ifdef ASM_SEQ_PERF_EN
  output logic [NEU_AW-1:0] out_addr,
  output logic [31:0]       busy_cycles
`else
  output logic [NEU_AW-1:0] out_addr
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BN    = 3'd1,
    S_CALC  = 3'd2,
    S_DRAIN = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [PIX_AW-1:0] IDX_LAST = PIX_AW'(N_INPUTS - 1);
  localparam logic [NEU_AW-1:0] NEU_LAST = NEU_AW'(N_NEURONS - 1);

  state_t            state_q, state_d;
  logic [PIX_AW-1:0] idx_q, idx_d;
  logic [NEU_AW-1:0] neu_q, neu_d;
  logic [PIX_AW-1:0] pix_addr_q, pix_addr_d;
  logic [W_AW-1:0]   w_addr_q, w_addr_d;
  logic [NEU_AW-1:0] bn_addr_q, bn_addr_d;
  logic [NEU_AW-1:0] out_addr_q, out_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              asm_reception_q, asm_reception_d;
  logic              calculate_en_q, calculate_en_d;
  logic              asm_send_q, asm_send_d;
  logic              out_we_q, out_we_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      neu_q           <= '0;
      pix_addr_q      <= '0;
      w_addr_q        <= '0;
      bn_addr_q       <= '0;
      out_addr_q      <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      asm_reception_q <= 1'b0;
      calculate_en_q  <= 1'b0;
      asm_send_q      <= 1'b0;
      out_we_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      neu_q           <= neu_d;
      pix_addr_q      <= pix_addr_d;
      w_addr_q        <= w_addr_d;
      bn_addr_q       <= bn_addr_d;
      out_addr_q      <= out_addr_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      asm_reception_q <= asm_reception_d;
      calculate_en_q  <= calculate_en_d;
      asm_send_q      <= asm_send_d;
      out_we_q        <= out_we_d;
    end
  end

  // Next state and counters; the input index wraps on its own, so it is already 0 for each new neuron.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    neu_d      = neu_q;
    out_addr_d = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BN;
          neu_d   = '0;
        end
      end
      S_BN:    state_d = S_CALC;
      S_CALC: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + PIX_AW'(1);
        end
      end
      S_DRAIN: state_d = S_SEND;
      S_SEND: begin
        out_addr_d = neu_q;
        if (neu_q == NEU_LAST) begin
          state_d = S_DONE;
          neu_d   = '0;
        end else begin
          state_d = S_BN;
          neu_d   = neu_q + NEU_AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address registers load only when entering their active state, so they hold elsewhere.
  always_comb begin
    pix_addr_d = pix_addr_q;
    w_addr_d   = w_addr_q;
    bn_addr_d  = bn_addr_q;
    if (state_d == S_BN) begin
      bn_addr_d = neu_d;
    end
    if (state_d == S_CALC) begin
      pix_addr_d = idx_d;
      if (state_q == S_BN && neu_q == '0) begin
        w_addr_d = '0;
      end else begin
        w_addr_d = w_addr_q + W_AW'(1);
      end
    end
  end

  // Each strobe fires the cycle after the state that owns it.
  always_comb begin
    busy_d          = (state_d != S_IDLE);
    done_d          = (state_d == S_DONE);
    asm_reception_d = (state_q == S_BN);
    calculate_en_d  = (state_q == S_CALC);
    asm_send_d      = (state_q == S_DRAIN);
    out_we_d        = (state_q == S_SEND);
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pix_addr      = pix_addr_q;
  assign w_addr        = w_addr_q;
  assign bn_addr       = bn_addr_q;
  assign out_addr      = out_addr_q;
  assign asm_reception = asm_reception_q;
  assign calculate_en  = calculate_en_q;
  assign asm_send      = asm_send_q;
  assign out_we        = out_we_q;

`ifdef ASM_SEQ_PERF_EN
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cycles_q <= '0;
    end else begin
      busy_cycles_q <= busy_cycles_d;
    end
  end

  // Saturating count of busy cycles, restarted on each accepted layer.
  always_comb begin
    busy_cycles_d = busy_cycles_q;
    if (state_q == S_IDLE && start) begin
      busy_cycles_d = '0;
    end else if (state_q != S_IDLE && busy_cycles_q != 32'hFFFF_FFFF) begin
      busy_cycles_d = busy_cycles_q + 32'd1;
    end
  end

  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_asm_seq_ctrl.sv
// Scoreboard bench for asm_seq_ctrl with N_INPUTS=4, N_NEURONS=3.
// Layer-relative cycle r: start accepted at edge 0, BN of neuron 0 is cycle 1.
module tb_asm_seq_ctrl;
  localparam int N_IN  = 4;
  localparam int N_NEU = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [1:0] pix_addr;
  logic [3:0] w_addr;
  logic [1:0] bn_addr;
  logic       asm_reception, calculate_en, asm_send, out_we;
  logic [1:0] out_addr;
`ifdef ASM_SEQ_PERF_EN
  logic [31:0] busy_cycles;
`endif

  asm_seq_ctrl #(.N_INPUTS(N_IN), .N_NEURONS(N_NEU)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .pix_addr(pix_addr),
    .w_addr(w_addr),
    .bn_addr(bn_addr),
    .asm_reception(asm_reception),
    .calculate_en(calculate_en),
    .asm_send(asm_send),
    .out_we(out_we),
`ifdef ASM_SEQ_PERF_EN
    .out_addr(out_addr),
    .busy_cycles(busy_cycles)
`else
    .out_addr(out_addr)
`endif
  );

  always #5 clk = ~clk;

  int cyc_abs = 0;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  typedef struct {
    int cyc;
    int addr;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s at abs cycle %0d: got %0d, expected %0d", name, cyc_abs, act, req);
    end
  endtask

  // Expected result writes of one layer whose accept edge follows abs cycle b.
  task automatic push_layer(input int b);
    exp_t e;
    for (int n = 0; n < N_NEU; n++) begin
      e.cyc  = b + 7 * n + 8;
      e.addr = n;
      e.last = (n == N_NEU - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every out_we or done must match the head of the scoreboard.
  exp_t mon_e;
  always @(negedge clk) begin
    if (out_we || done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_out_we", int'(out_we), 0);
        check_output("unexpected_done", int'(done), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("result_cycle", cyc_abs, mon_e.cyc);
        check_output("result_out_we", int'(out_we), 1);
        check_output("result_out_addr", int'(out_addr), mon_e.addr);
        check_output("result_done", int'(done), int'(mon_e.last));
      end
    end
  end

  // Called at a negedge; raises start so the next edge is the accept edge.
  task automatic apply_stimulus(input bit hold, output int base);
    start = 1'b1;
    base  = cyc_abs;
    push_layer(base);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_rel(input int base, input int r);
    while (cyc_abs - base < r) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_done"}, int'(done), 0);
    check_output({tag, "_pix_addr"}, int'(pix_addr), 0);
    check_output({tag, "_w_addr"}, int'(w_addr), 0);
    check_output({tag, "_bn_addr"}, int'(bn_addr), 0);
    check_output({tag, "_reception"}, int'(asm_reception), 0);
    check_output({tag, "_calc_en"}, int'(calculate_en), 0);
    check_output({tag, "_send"}, int'(asm_send), 0);
    check_output({tag, "_out_we"}, int'(out_we), 0);
    check_output({tag, "_out_addr"}, int'(out_addr), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at abs cycle %0d", cyc_abs);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n, p;
    bit act;

    repeat (3) @(negedge clk);
    check_all_zero("reset_held");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_state");

    // Full layer with a cycle-by-cycle sweep of strobes and addresses.
    apply_stimulus(1'b0, base);
    for (int r = 1; r <= 23; r++) begin
      wait_rel(base, r);
      n   = (r - 1) / 7;
      p   = (r - 1) % 7;
      act = (r <= 21);
      check_output("sweep_busy", int'(busy), int'(r <= 22));
      check_output("sweep_done", int'(done), int'(r == 22));
      check_output("sweep_reception", int'(asm_reception), int'(act && p == 1));
      check_output("sweep_calc_en", int'(calculate_en), int'(act && p >= 2 && p <= 5));
      check_output("sweep_send", int'(asm_send), int'(act && p == 6));
      if (act && p >= 1 && p <= 4) begin
        check_output("sweep_pix_addr", int'(pix_addr), p - 1);
        check_output("sweep_w_addr", int'(w_addr), n * N_IN + p - 1);
      end
      if (act && p == 0) check_output("sweep_bn_addr", int'(bn_addr), n);
`ifdef ASM_SEQ_PERF_EN
      if (r == 22) check_output("perf_in_done", int'(busy_cycles), 21);
      if (r == 23) check_output("perf_after_done", int'(busy_cycles), 22);
`endif
    end
    check_output("hold_w_addr", int'(w_addr), 11);
    repeat (3) @(negedge clk);

    // start while busy and in the DONE cycle is ignored.
    apply_stimulus(1'b0, base);
    wait_rel(base, 5);
    start = 1'b1;
    wait_rel(base, 6);
    start = 1'b0;
    check_output("busy_ignored_start", int'(busy), 1);
    wait_rel(base, 22);
    start = 1'b1;
    wait_rel(base, 23);
    start = 1'b0;
    for (int r = 23; r <= 30; r++) begin
      wait_rel(base, r);
      check_output("no_restart_busy", int'(busy), 0);
    end

    // start held high: second layer BN at cycle 24, done at 22 and 45.
    apply_stimulus(1'b1, base);
    push_layer(base + 23);
    wait_rel(base, 23);
    check_output("held_gap_busy", int'(busy), 0);
    wait_rel(base, 24);
    start = 1'b0;
    check_output("held_second_busy", int'(busy), 1);
    check_output("held_second_bn", int'(bn_addr), 0);
`ifdef ASM_SEQ_PERF_EN
    check_output("perf_cleared", int'(busy_cycles), 0);
`endif
    wait_rel(base, 47);
    check_output("held_end_busy", int'(busy), 0);

    // Reset mid-layer aborts; a fresh start reruns from neuron 0.
    apply_stimulus(1'b0, base);
    wait_rel(base, 12);
    check_output("pre_abort_calc_en", int'(calculate_en), 1);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check_output("post_abort_busy", int'(busy), 0);
    apply_stimulus(1'b0, base);
    wait_rel(base, 1);
    check_output("rerun_busy", int'(busy), 1);
    check_output("rerun_bn_addr", int'(bn_addr), 0);
    wait_rel(base, 2);
    check_output("rerun_reception", int'(asm_reception), 1);
    check_output("rerun_w_addr", int'(w_addr), 0);
    check_output("rerun_pix_addr", int'(pix_addr), 0);
    wait_rel(base, 23);
`ifdef ASM_SEQ_PERF_EN
    check_output("perf_rerun", int'(busy_cycles), 22);
`endif
    wait_rel(base, 26);
    check_output("pending_results", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
